// File: rtl/jb_oran_lphy_stat_cnt.sv
// O-RAN LPHY statistics stage: saturating live event counters, sticky error bits,
// a shadow bank captured on snapshot, and a registered 1-cycle-latency read port.
module jb_oran_lphy_stat_cnt #(
   parameter int NUM_CNT     = 20,
   parameter int CNT_W       = 32,
   parameter int STICKY_W    = 16,
   parameter int CLR_ON_SNAP = 1,
   localparam int ADDR_W     = $clog2(NUM_CNT + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_CNT-1:0]  evt_i,
   input  logic [STICKY_W-1:0] sticky_i,
   input  logic                snap_req_i,
   input  logic                clr_i,
   output logic                snap_done_o,
   input  logic                rd_en_i,
   input  logic [ADDR_W-1:0]   rd_addr_i,
   output logic                rd_vld_o,
   output logic [31:0]         rd_data_o,
   output logic                sat_o
);

   logic [CNT_W-1:0]    cnt_q    [NUM_CNT];
   logic [CNT_W-1:0]    cnt_inc  [NUM_CNT];
   logic [CNT_W-1:0]    cnt_d    [NUM_CNT];
   logic [CNT_W-1:0]    shad_q   [NUM_CNT];
   logic [STICKY_W-1:0] sticky_q;
   logic [STICKY_W-1:0] sticky_acc;
   logic [STICKY_W-1:0] sticky_d;
   logic [STICKY_W-1:0] shad_sticky_q;
   logic                sat_q;
   logic                sat_d;
   logic                snap_done_q;
   logic                rd_vld_q;
   logic [31:0]         rd_data_q;
   logic [31:0]         rd_word;
   logic                live_clr;
   logic                clr_only;

   // A snapshot only clears the live bank when CLR_ON_SNAP is set; clr_i always does.
   assign live_clr = clr_i | (snap_req_i & (CLR_ON_SNAP != 0));
   assign clr_only = clr_i & ~snap_req_i;

   // Saturating increment is also the value the shadow captures, before any clear.
   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) begin
         if (cnt_q[i] == {CNT_W{1'b1}}) begin
            cnt_inc[i] = cnt_q[i];
         end else begin
            cnt_inc[i] = cnt_q[i] + CNT_W'(evt_i[i]);
         end
      end
   end

   // A bare clr_i keeps same-cycle events; with a snapshot they belong to the shadow.
   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) begin
         if (clr_only) begin
            cnt_d[i] = CNT_W'(evt_i[i]);
         end else if (live_clr) begin
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_inc[i];
         end
      end
   end

   always_comb begin
      sticky_acc = sticky_q | sticky_i;
      if (clr_only) begin
         sticky_d = sticky_i;
      end else if (live_clr) begin
         sticky_d = '0;
      end else begin
         sticky_d = sticky_acc;
      end
   end

   // sat_o survives snapshot clears; only clr_i (or reset) drops it.
   always_comb begin
      sat_d = clr_i ? 1'b0 : sat_q;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (cnt_d[i] == {CNT_W{1'b1}}) begin
            sat_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= '0;
         end
         sticky_q <= '0;
         sat_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         sticky_q <= sticky_d;
         sat_q    <= sat_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            shad_q[i] <= '0;
         end
         shad_sticky_q <= '0;
         snap_done_q   <= 1'b0;
      end else begin
         snap_done_q <= snap_req_i;
         if (snap_req_i) begin
            for (int i = 0; i < NUM_CNT; i++) begin
               shad_q[i] <= cnt_inc[i];
            end
            shad_sticky_q <= sticky_acc;
         end
      end
   end

   // Read mux sees the pre-snapshot shadow, so a colliding read returns the old value.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (int'(rd_addr_i) == i) begin
            rd_word[CNT_W-1:0] = shad_q[i];
         end
      end
      if (int'(rd_addr_i) == NUM_CNT) begin
         rd_word[STICKY_W-1:0] = shad_sticky_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_vld_q <= rd_en_i;
         if (rd_en_i) begin
            rd_data_q <= rd_word;
         end
      end
   end

   assign snap_done_o = snap_done_q;
   assign rd_vld_o    = rd_vld_q;
   assign rd_data_o   = rd_data_q;
   assign sat_o       = sat_q;

endmodule
